// File: rtl/rvh_noc_pkg.sv
// Shared NoC definitions: VC id width, QoS VC reservation default and credit count type.
package rvh_noc_pkg;

   localparam int unsigned VC_ID_NUM_MAX_W      = 3;
   localparam int unsigned QOS_VC_NUM_PER_INPUT = 0;
   localparam int unsigned VC_DEPTH_DEF         = 4;
   localparam int unsigned CRD_W_DEF            = $clog2(VC_DEPTH_DEF + 1);

   typedef logic [CRD_W_DEF-1:0] vc_crd_t;

endpackage

// File: rtl/rr_arbiter_vc.sv
// Round-robin pick over an N-wide request vector, searching upward from an external pointer.
module rr_arbiter_vc #(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt_oh,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_vld
);

   int k;

   always_comb begin
      gnt_oh  = '0;
      gnt_idx = '0;
      gnt_vld = 1'b0;
      k       = 0;
      for (int i = 0; i < int'(N); i++) begin
         k = (int'(ptr) + i) % int'(N);
         if (!gnt_vld && req[IDX_W'(k)]) begin
            gnt_vld            = 1'b1;
            gnt_oh[IDX_W'(k)]  = 1'b1;
            gnt_idx            = IDX_W'(k);
         end
      end
   end

endmodule

// File: rtl/input_port_vc_credit_alloc.sv
// Sender-side credit tracking and per-flit VC allocation for a link into a downstream input port.
module input_port_vc_credit_alloc
   import rvh_noc_pkg::*;
#(
   parameter int unsigned VC_NUM       = 4,
   parameter int unsigned VC_NUM_IDX_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1,
   parameter int unsigned VC_DEPTH     = 4,
   parameter int unsigned CRD_W        = $clog2(VC_DEPTH + 1),
   parameter int unsigned RT_VC_NUM    = QOS_VC_NUM_PER_INPUT
) (
   input  logic                       clk,
   input  logic                       rstn,
   input  logic                       req_vld_i,
   input  logic                       req_rt_i,
   output logic                       req_rdy_o,
   input  logic [VC_NUM-1:0]          vc_mask_i,
   output logic                       flit_v_o,
   output logic [VC_NUM_IDX_W-1:0]    flit_vc_id_o,
   input  logic                       lcrd_v_i,
   input  logic [VC_ID_NUM_MAX_W-1:0] lcrd_id_i,
   output logic [VC_NUM*CRD_W-1:0]    vc_credit_o,
   output logic                       crd_err_o
);

   logic [VC_NUM-1:0][CRD_W-1:0] credit_q, credit_d;
   logic [VC_NUM_IDX_W-1:0]      ptr_q, ptr_d;
   logic                         crd_err_q, crd_err_d;
   logic [VC_NUM-1:0]            elig, gnt_oh;
   logic [VC_NUM_IDX_W-1:0]      gnt_idx;
   logic                         gnt_vld, class_ok, gnt_v, ret_v;

   // A VC is eligible when it holds credit, is enabled and matches the flit's QoS class.
   always_comb begin
      elig     = '0;
      class_ok = 1'b1;
      for (int v = 0; v < int'(VC_NUM); v++) begin
         class_ok = (RT_VC_NUM == 0) ||
                    (req_rt_i ? (v < int'(RT_VC_NUM)) : (v >= int'(RT_VC_NUM)));
         elig[v]  = (credit_q[v] != '0) & vc_mask_i[v] & class_ok;
      end
   end

   rr_arbiter_vc #(
      .N     (VC_NUM),
      .IDX_W (VC_NUM_IDX_W)
   ) u_rr (
      .req     (elig),
      .ptr     (ptr_q),
      .gnt_oh  (gnt_oh),
      .gnt_idx (gnt_idx),
      .gnt_vld (gnt_vld)
   );

   // No launch while reset is held, so nothing escapes the accounting being cleared.
   assign req_rdy_o    = req_vld_i & rstn & gnt_vld;
   assign flit_v_o     = req_rdy_o;
   assign flit_vc_id_o = gnt_idx;
   assign vc_credit_o  = credit_q;
   assign crd_err_o    = crd_err_q;

   always_comb begin
      ptr_d = ptr_q;
      if (req_rdy_o) begin
         ptr_d = (gnt_idx == VC_NUM_IDX_W'(VC_NUM - 1)) ? '0 : gnt_idx + VC_NUM_IDX_W'(1);
      end
   end

   // Grant and return on the same VC cancel; a return to a full counter saturates and flags.
   always_comb begin
      credit_d  = credit_q;
      crd_err_d = crd_err_q;
      gnt_v     = 1'b0;
      ret_v     = 1'b0;
      if (lcrd_v_i && (32'(lcrd_id_i) >= VC_NUM)) begin
         crd_err_d = 1'b1;
      end
      for (int v = 0; v < int'(VC_NUM); v++) begin
         gnt_v = req_rdy_o & gnt_oh[v];
         ret_v = lcrd_v_i & (32'(lcrd_id_i) == 32'(v));
         if (gnt_v && !ret_v) begin
            credit_d[v] = credit_q[v] - CRD_W'(1);
         end else if (ret_v && !gnt_v) begin
            if (credit_q[v] == CRD_W'(VC_DEPTH)) begin
               crd_err_d = 1'b1;
            end else begin
               credit_d[v] = credit_q[v] + CRD_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         credit_q  <= {VC_NUM{CRD_W'(VC_DEPTH)}};
         ptr_q     <= '0;
         crd_err_q <= 1'b0;
      end else begin
         credit_q  <= credit_d;
         ptr_q     <= ptr_d;
         crd_err_q <= crd_err_d;
      end
   end

endmodule
